// File: rtl/cursor_if.sv
// cursor_if: joystick-side inputs and cursor-side outputs of cursor_ctrl
interface cursor_if #(
  parameter int CW = 10,
  parameter int JW = 10
);
  logic          clk_cursor;
  logic          en;
  logic          home;
  logic [JW-1:0] joy_x;
  logic [JW-1:0] joy_y;
  logic [CW-1:0] dot_x;
  logic [CW-1:0] dot_y;
  logic          moved;
  logic [3:0]    at_bound;
  modport master (output clk_cursor, en, home, joy_x, joy_y, input dot_x, dot_y, moved, at_bound);
  modport slave  (input clk_cursor, en, home, joy_x, joy_y, output dot_x, dot_y, moved, at_bound);
endinterface

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: joystick cursor with deadzone, 2-speed steps, hold-to-accelerate and bounds (CURSOR_WRAP_EN: wrap instead of clamp)
module cursor_ctrl #(
  parameter int CW          = 10,
  parameter int JW          = 10,
  parameter int INIT_X      = 204,
  parameter int INIT_Y      = 171,
  parameter int X_LB        = 194,
  parameter int X_UB        = 354,
  parameter int Y_LB        = 71,
  parameter int Y_UB        = 471,
  parameter int TH_LO_FAST  = 150,
  parameter int TH_LO_SLOW  = 400,
  parameter int TH_HI_SLOW  = 600,
  parameter int TH_HI_FAST  = 850,
  parameter int STEP_SLOW   = 10,
  parameter int STEP_FAST   = 20,
  parameter bit X_INV       = 1'b1,
  parameter bit Y_INV       = 1'b0,
  parameter int ACCEL_TICKS = 4
) (
  input logic     clk,
  input logic     clr,
  cursor_if.slave bus
);
  typedef logic signed [CW+1:0] sw_t;
  typedef struct packed {
    logic [CW-1:0] pos;
    logic [3:0]    cnt;
    logic [1:0]    sg;
  } axis_t;
  localparam sw_t XL = sw_t'(X_LB);
  localparam sw_t XU = sw_t'(X_UB);
  localparam sw_t YL = sw_t'(Y_LB);
  localparam sw_t YU = sw_t'(Y_UB);
  localparam sw_t SS = sw_t'(STEP_SLOW);
  localparam sw_t SF = sw_t'(STEP_FAST);
  localparam logic [JW-1:0] TLF = JW'(TH_LO_FAST);
  localparam logic [JW-1:0] TLS = JW'(TH_LO_SLOW);
  localparam logic [JW-1:0] THS = JW'(TH_HI_SLOW);
  localparam logic [JW-1:0] THF = JW'(TH_HI_FAST);
  localparam logic [CW-1:0] IX = CW'(INIT_X);
  localparam logic [CW-1:0] IY = CW'(INIT_Y);
  function automatic axis_t step_axis(input logic [CW-1:0] p, input logic [JW-1:0] r,
                                      input logic [3:0] c, input logic [1:0] s,
                                      input logic inv, input sw_t lb, input sw_t ub);
    logic lo, hi, nz, up, over, under;
    logic [1:0] ns;
    sw_t st, n;
    axis_t o;
    lo = r < TLS;
    hi = r > THS;
    nz = lo | hi;
    up = hi ^ inv;
    st = (r < TLF || r > THF) ? SF : SS;
    if (ACCEL_TICKS != 0 && int'(c) >= ACCEL_TICKS) st = st + st;
    n = sw_t'({2'b00, p}) + (nz ? (up ? st : -st) : '0);
    ns = nz ? {~up, up} : s;
    over = n > ub;
    under = n < lb;
    o.cnt = (nz && (s == 2'b00 || s == ns)) ? (c == 4'hf ? c : c + 4'd1) : 4'd0;
    o.sg = ns;
`ifdef CURSOR_WRAP_EN
    o.pos = over ? lb[CW-1:0] : under ? ub[CW-1:0] : n[CW-1:0];
    if (over | under) o.cnt = 4'd0;
`else
    o.pos = over ? ub[CW-1:0] : under ? lb[CW-1:0] : n[CW-1:0];
`endif
    return o;
  endfunction
  logic [CW-1:0] x_q, y_q;
  logic [3:0]    cx_q, cy_q;
  logic [1:0]    sx_q, sy_q;
  logic          tick_q, moved_q, tick;
  axis_t         ax, ay;
  assign tick = bus.clk_cursor & ~tick_q;
  assign ax = step_axis(x_q, bus.joy_x, cx_q, sx_q, X_INV, XL, XU);
  assign ay = step_axis(y_q, bus.joy_y, cy_q, sy_q, Y_INV, YL, YU);
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      x_q <= IX;
      y_q <= IY;
      cx_q <= 4'd0;
      cy_q <= 4'd0;
      sx_q <= 2'b00;
      sy_q <= 2'b00;
      tick_q <= 1'b0;
      moved_q <= 1'b0;
    end else begin
      tick_q <= bus.clk_cursor;
      if (bus.home) begin
        x_q <= IX;
        y_q <= IY;
        cx_q <= 4'd0;
        cy_q <= 4'd0;
        sx_q <= 2'b00;
        sy_q <= 2'b00;
        moved_q <= (x_q != IX) || (y_q != IY);
      end else if (tick && bus.en) begin
        x_q <= ax.pos;
        y_q <= ay.pos;
        cx_q <= ax.cnt;
        cy_q <= ay.cnt;
        sx_q <= ax.sg;
        sy_q <= ay.sg;
        moved_q <= (ax.pos != x_q) || (ay.pos != y_q);
      end else begin
        moved_q <= 1'b0;
      end
    end
  end
  assign bus.dot_x = x_q;
  assign bus.dot_y = y_q;
  assign bus.moved = moved_q;
  assign bus.at_bound = {x_q == XL[CW-1:0], x_q == XU[CW-1:0], y_q == YL[CW-1:0], y_q == YU[CW-1:0]};
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed and randomized checks of cursor_ctrl against a behavioural model
module tb_cursor_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b1;
  cursor_if #(.CW(10), .JW(10)) bus ();
  cursor_ctrl dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  int cmp_n = 0;
  int fail_n = 0;
  int mx, my, mcx, mcy, msx, msy;
  bit mmoved, mtq;

  function automatic logic [24:0] mvec();
    logic [9:0] ex, ey;
    ex = 10'(mx);
    ey = 10'(my);
    return {ex, ey, mmoved, mx == 194, mx == 354, my == 71, my == 471};
  endfunction

  function automatic logic [24:0] obs();
    return {bus.dot_x, bus.dot_y, bus.moved, bus.at_bound};
  endfunction

  task automatic m_home();
    mx = 204; my = 171; mcx = 0; mcy = 0; msx = 0; msy = 0;
  endtask

  task automatic m_axis(input int r, input bit inv, input int lb, input int ub,
                        inout int p, inout int c, inout int s);
    int d, sg, st, n;
    d = r < 150 ? -2 : r < 400 ? -1 : r > 850 ? 2 : r > 600 ? 1 : 0;
    if (inv) d = -d;
    if (d == 0) begin
      c = 0;
      return;
    end
    sg = d > 0 ? 1 : -1;
    st = (d * sg == 2 ? 20 : 10) * (c >= 4 ? 2 : 1);
    c = (s == 0 || s == sg) ? (c < 15 ? c + 1 : 15) : 0;
    s = sg;
    n = p + sg * st;
`ifdef CURSOR_WRAP_EN
    if (n > ub) begin p = lb; c = 0; end
    else if (n < lb) begin p = ub; c = 0; end
    else p = n;
`else
    p = n > ub ? ub : n < lb ? lb : n;
`endif
  endtask

  task automatic cyc(input bit cc, input bit e, input bit h, input int jx, input int jy);
    int px, py;
    bit tk;
    bus.clk_cursor = cc;
    bus.en = e;
    bus.home = h;
    bus.joy_x = 10'(jx);
    bus.joy_y = 10'(jy);
    tk = cc && !mtq;
    mtq = cc;
    px = mx;
    py = my;
    if (h) m_home();
    else if (tk && e) begin
      m_axis(jx, 1'b1, 194, 354, mx, mcx, msx);
      m_axis(jy, 1'b0, 71, 471, my, mcy, msy);
    end
    mmoved = (mx != px) || (my != py);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.clk_cursor = 1'b0; bus.en = 1'b1; bus.home = 1'b0; bus.joy_x = 10'd512; bus.joy_y = 10'd512;
    #12;
    m_home(); mmoved = 0; mtq = 0;
    if (obs() !== {10'd204, 10'd171, 1'b0, 4'b0000}) begin
      fail_n++; $display("FAIL reset_init: got %h want %h", obs(), {10'd204, 10'd171, 1'b0, 4'b0000});
    end
    cmp_n++;
    @(negedge clk); clr = 1'b0;
    cyc(1, 1, 0, 512, 900);
    if (obs() !== mvec() || bus.dot_y !== 10'd191) begin
      fail_n++; $display("FAIL reset_premove: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(0, 1, 0, 512, 900);
    @(posedge clk); #2 clr = 1'b1; #1;
    m_home(); mmoved = 0; mtq = 0;
    if (obs() !== {10'd204, 10'd171, 1'b0, 4'b0000}) begin
      fail_n++; $display("FAIL reset_async: got %h want %h", obs(), {10'd204, 10'd171, 1'b0, 4'b0000});
    end
    cmp_n++;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_speed();
    cyc(1, 1, 0, 300, 512);
    if (obs() !== mvec() || bus.dot_x !== 10'd214 || bus.moved !== 1'b1) begin
      fail_n++; $display("FAIL speed_slow: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(0, 1, 0, 300, 512);
    if (obs() !== mvec() || bus.moved !== 1'b0) begin
      fail_n++; $display("FAIL speed_pulse: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(1, 1, 0, 100, 512);
    if (obs() !== mvec() || bus.dot_x !== 10'd234) begin
      fail_n++; $display("FAIL speed_fast: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(0, 1, 0, 100, 512);
  endtask

  task automatic test_deadzone();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 512, 400);
      if (obs() !== mvec() || bus.dot_x !== 10'd234 || bus.dot_y !== 10'd171 || bus.moved !== 1'b0) begin
        fail_n++; $display("FAIL deadzone_%0d: got %h want %h", i, obs(), mvec());
      end
      cmp_n++;
      cyc(0, 1, 0, 512, 400);
    end
  endtask

  task automatic test_accel();
    int exp_y[5] = '{191, 211, 231, 251, 291};
    cyc(1, 1, 1, 512, 512);
    cyc(0, 1, 0, 512, 512);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 512, 900);
      if (obs() !== mvec() || int'(bus.dot_y) != exp_y[i]) begin
        fail_n++; $display("FAIL accel_%0d: got %h want %h dot_y=%0d/%0d", i, obs(), mvec(), bus.dot_y, exp_y[i]);
      end
      cmp_n++;
      cyc(0, 1, 0, 512, 900);
    end
    cyc(1, 1, 0, 512, 512);
    cyc(0, 1, 0, 512, 512);
    cyc(1, 1, 0, 512, 900);
    if (obs() !== mvec() || bus.dot_y !== 10'd311) begin
      fail_n++; $display("FAIL accel_restart: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(0, 1, 0, 512, 900);
  endtask

  task automatic test_clamp();
    int ex1, ex2, ey;
    bit em2;
`ifdef CURSOR_WRAP_EN
    ex1 = 194; ex2 = 214; em2 = 1'b1; ey = 471;
`else
    ex1 = 354; ex2 = 354; em2 = 1'b0; ey = 71;
`endif
    cyc(1, 1, 1, 512, 512);
    cyc(0, 1, 0, 512, 512);
    for (int i = 0; i < 20 && mx < 344; i++) begin
      cyc(1, 1, 0, 300, 512);
      cyc(0, 1, 0, 300, 512);
    end
    if (obs() !== mvec() || bus.dot_x !== 10'd344) begin
      fail_n++; $display("FAIL clamp_pre: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(1, 1, 0, 100, 512);
    if (obs() !== mvec() || int'(bus.dot_x) != ex1) begin
      fail_n++; $display("FAIL clamp_x_hit: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(0, 1, 0, 100, 512);
    cyc(1, 1, 0, 100, 512);
    if (obs() !== mvec() || int'(bus.dot_x) != ex2 || bus.moved !== em2) begin
      fail_n++; $display("FAIL clamp_x_hold: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(0, 1, 0, 100, 512);
    cyc(1, 1, 1, 512, 512);
    cyc(0, 1, 0, 512, 512);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0, 512, i < 4 ? 100 : i == 4 ? 512 : 300);
      cyc(0, 1, 0, 512, 512);
    end
    if (obs() !== mvec() || bus.dot_y !== 10'd81) begin
      fail_n++; $display("FAIL clamp_y_pre: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(1, 1, 0, 512, 100);
    if (obs() !== mvec() || int'(bus.dot_y) != ey) begin
      fail_n++; $display("FAIL clamp_y_hit: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(0, 1, 0, 512, 100);
  endtask

  task automatic test_home();
    cyc(1, 1, 1, 512, 512);
    cyc(0, 1, 0, 512, 512);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 300, 512);
      cyc(0, 1, 0, 300, 512);
    end
    if (obs() !== mvec() || bus.dot_x !== 10'd234) begin
      fail_n++; $display("FAIL home_pre: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(1, 1, 1, 300, 512);
    if (obs() !== mvec() || bus.dot_x !== 10'd204 || bus.dot_y !== 10'd171 || bus.moved !== 1'b1) begin
      fail_n++; $display("FAIL home_tick: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(0, 1, 0, 300, 512);
  endtask

  task automatic test_enable();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 100, 100);
      if (obs() !== mvec() || bus.dot_x !== 10'd204 || bus.dot_y !== 10'd171 || bus.moved !== 1'b0) begin
        fail_n++; $display("FAIL enable_off_%0d: got %h want %h", i, obs(), mvec());
      end
      cmp_n++;
      cyc(0, 0, 0, 100, 100);
    end
    cyc(1, 1, 0, 100, 100);
    if (obs() !== mvec()) begin
      fail_n++; $display("FAIL enable_on: got %h want %h", obs(), mvec());
    end
    cmp_n++;
    cyc(0, 1, 0, 100, 100);
  endtask

  task automatic test_random();
    int jx = 512, jy = 512;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) jx = $urandom_range(0, 1023);
      if ($urandom_range(0, 7) == 0) jy = $urandom_range(0, 1023);
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0, $urandom_range(0, 47) == 0, jx, jy);
      if (obs() !== mvec()) begin
        fail_n++; $display("FAIL random_%0d: got %h want %h", i, obs(), mvec());
      end
      cmp_n++;
    end
  endtask

  initial begin
    test_reset();
    test_speed();
    test_deadzone();
    test_accel();
    test_clamp();
    test_home();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
